// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
// Contents:
//   state_e : serializer FSM state (IDLE waits for a word, SHIFT emits bits)
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Frame bit counter for the serializer.
// Counts 0..WIDTH-1 while en is high and wraps to 0 after WIDTH-1.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (clears the count)
//   en    : advance the count this cycle
//   count : current bit index within the frame
//   last  : count is at WIDTH-1 (last bit of a frame)
//   wrap  : count advances out of WIDTH-1 this cycle (frame end)
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST_CNT) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_CNT);
  assign wrap  = en && (count_q == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with valid/ready load handshake.
// A word is accepted when load_valid and load_ready are both high on a
// rising edge; its first bit appears on serial_out one cycle later. Bits
// advance only while enable is high. A word offered during the last-bit
// cycle starts the next frame with no idle gap.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   enable       : shift advance qualifier
//   load_valid   : data_in is offered
//   data_in      : parallel word to serialize (WIDTH bits)
//   load_ready   : a word can be accepted this cycle
//   serial_out   : current serial bit (registered)
//   serial_valid : serial_out carries frame data
//   done         : high while the last bit of a frame is presented
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;

  logic [CW-1:0]    cnt;
  logic             cnt_en;
  logic             cnt_last;
  logic             cnt_wrap;
  logic             accept;

  // The counter only moves while a frame is being shifted; in IDLE it
  // sits at 0, which is exactly where a fresh frame must start.
  assign cnt_en = (state_q == SHIFT) && enable;

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last),
    .wrap  (cnt_wrap)
  );

  // In SHIFT a new word may only enter in the cycle the last bit is
  // leaving, so the in-flight frame can never be disturbed.
  assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_last && enable);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = serial_valid_q;
    if (accept) begin
      state_d        = SHIFT;
      shreg_d        = data_in;
      serial_out_d   = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
      serial_valid_d = 1'b1;
    end else if (cnt_wrap) begin
      state_d        = IDLE;
      shreg_d        = '0;
      serial_out_d   = 1'b0;
      serial_valid_d = 1'b0;
    end else if (cnt_en) begin
      // serial_out already shows the current end bit, so the next bit
      // is the neighbour one position in from that end.
      shreg_d      = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
      serial_out_d = (MSB_FIRST != 0) ? shreg_q[WIDTH-2] : shreg_q[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign done         = (state_q == SHIFT) && cnt_last;

endmodule
